// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game-level control blocks.
//   state_t          : game state encoding (NEWGAME, PLAY, NEWBALL, OVER)
//   NUM_BALLS_DEF    : default number of balls per game
//   SERVE_FRAMES_DEF : default pause, in frames, after a miss and after game over
//   BCD_MAX          : saturation value of the two-digit BCD score
//   bcd2_inc()       : saturating two-digit BCD increment
package pong_pkg;

   typedef enum logic [1:0] {
      ST_NEWGAME = 2'd0,
      ST_PLAY    = 2'd1,
      ST_NEWBALL = 2'd2,
      ST_OVER    = 2'd3
   } state_t;

   localparam int          NUM_BALLS_DEF    = 3;
   localparam int          SERVE_FRAMES_DEF = 120;
   localparam logic [7:0]  BCD_MAX          = 8'h99;

   // Units roll 9 -> 0 with a carry into the tens; 99 holds.
   function automatic logic [7:0] bcd2_inc(input logic [7:0] value);
      logic [7:0] result;
      if (value >= BCD_MAX)
         result = BCD_MAX;
      else if (value[3:0] == 4'd9)
         result = {value[7:4] + 4'd1, 4'd0};
      else
         result = {value[7:4], value[3:0] + 4'd1};
      return result;
   endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the Pong graphics generator and the game controller.
//   refr_tick  : one-cycle pulse per frame (start of vertical retrace)
//   btn        : paddle buttons, level, already synchronised
//   hit / miss : one-cycle ball events from the graphics generator
//   gra_still  : hold ball at serve position, paddle idle
//   serve      : one-cycle pulse launching the ball
//   state      : current game state
//   balls_left : remaining balls including the one in play
//   score_bcd  : two BCD digits, [7:4] tens, [3:0] units
// Modports: master = graphics side, slave = game controller.
interface pong_game_ctrl_if;
   import pong_pkg::*;

   logic       refr_tick;
   logic [1:0] btn;
   logic       hit;
   logic       miss;
   logic       gra_still;
   logic       serve;
   state_t     state;
   logic [1:0] balls_left;
   logic [7:0] score_bcd;

   modport master (
      output refr_tick, btn, hit, miss,
      input  gra_still, serve, state, balls_left, score_bcd
   );

   modport slave (
      input  refr_tick, btn, hit, miss,
      output gra_still, serve, state, balls_left, score_bcd
   );

endinterface

// File: rtl/pong_bcd2_counter.sv
// Two-digit BCD counter, saturating at 99.
//   clk   : clock
//   reset : synchronous, active-high, clears the count
//   clr   : synchronous clear, has priority over inc
//   inc   : count up by one BCD step
//   count : current value, [7:4] tens, [3:0] units
module pong_bcd2_counter
   import pong_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       inc,
   output logic [7:0] count
);

   // NOTE: registers are updated with non-blocking assignments so every
   // always_ff reads the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (reset || clr)
         count <= 8'h00;
      else if (inc)
         count <= bcd2_inc(count);
   end

endmodule

// File: rtl/pong_game_ctrl.sv
// Game-level sequencer for the Pong display pipeline.
// Runs the NEWGAME / PLAY / NEWBALL / OVER state machine, counts the balls
// left and the BCD score, and tells the graphics generator when to freeze
// the ball and when to serve.
//   clk   : 50 MHz pixel-domain clock
//   reset : synchronous, active-high
//   bus   : slave side of pong_game_ctrl_if (frame tick, buttons, hit/miss
//           in; gra_still, serve, state, balls_left, score_bcd out)
// Parameters:
//   NUM_BALLS    : balls per game (1..3)
//   SERVE_FRAMES : frames of forced pause after a miss and after game over
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int NUM_BALLS    = NUM_BALLS_DEF,
   parameter int SERVE_FRAMES = SERVE_FRAMES_DEF
) (
   input  logic             clk,
   input  logic             reset,
   pong_game_ctrl_if.slave  bus
);

   localparam int               TW         = $clog2(SERVE_FRAMES + 1);
   localparam logic [TW-1:0]    TIMER_LOAD = TW'(SERVE_FRAMES);
   localparam logic [1:0]       BALLS_LOAD = 2'(NUM_BALLS);

   state_t        state;
   logic          gra_still;
   logic          serve;
   logic [1:0]    balls_left;
   logic [TW-1:0] timer;
   logic          btn_prev;

   logic          any_btn;
   logic          start_edge;
   logic          score_clr;
   logic          score_inc;
   logic [7:0]    score_bcd;

   assign any_btn    = bus.btn[1] | bus.btn[0];
   assign start_edge = any_btn & ~btn_prev;

   // Score is cleared on the same edge that starts a game, so the first
   // PLAY cycle already shows 00; a hit only counts when no miss collides.
   assign score_clr = (state == ST_NEWGAME) && start_edge;
   assign score_inc = (state == ST_PLAY) && bus.hit && !bus.miss;

   pong_bcd2_counter u_score (
      .clk   (clk),
      .reset (reset),
      .clr   (score_clr),
      .inc   (score_inc),
      .count (score_bcd)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_NEWGAME;
         gra_still  <= 1'b1;
         serve      <= 1'b0;
         balls_left <= BALLS_LOAD;
         timer      <= '0;
         // A button held across reset looks "already pressed", so it
         // cannot start a game until it is released and pressed again.
         btn_prev   <= 1'b1;
      end else begin
         btn_prev <= any_btn;
         // NOTE: serve defaults low every cycle so any branch that raises it
         // produces exactly a one-cycle pulse.
         serve    <= 1'b0;

         // The load below (entry into NEWBALL/OVER) overrides this, so a
         // frame tick in the entry cycle is not counted.
         if (bus.refr_tick && timer != '0)
            timer <= timer - TW'(1);

         unique case (state)
            ST_NEWGAME: begin
               if (start_edge) begin
                  state      <= ST_PLAY;
                  gra_still  <= 1'b0;
                  serve      <= 1'b1;
                  balls_left <= BALLS_LOAD;
               end
            end

            ST_PLAY: begin
               if (bus.miss) begin
                  gra_still <= 1'b1;
                  timer     <= TIMER_LOAD;
                  if (balls_left > 2'd1) begin
                     balls_left <= balls_left - 2'd1;
                     state      <= ST_NEWBALL;
                  end else begin
                     balls_left <= 2'd0;
                     state      <= ST_OVER;
                  end
               end
            end

            ST_NEWBALL: begin
               // Button is level-sensitive here: holding it through the
               // pause serves as soon as the pause ends.
               if (timer == '0 && any_btn) begin
                  state     <= ST_PLAY;
                  gra_still <= 1'b0;
                  serve     <= 1'b1;
               end
            end

            ST_OVER: begin
               if (timer == '0)
                  state <= ST_NEWGAME;
            end

            default: state <= ST_NEWGAME;
         endcase
      end
   end

   assign bus.state      = state;
   assign bus.gra_still  = gra_still;
   assign bus.serve      = serve;
   assign bus.balls_left = balls_left;
   assign bus.score_bcd  = score_bcd;

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-level sequencer for the Pong display pipeline. Runs the new-game / play / new-ball / game-over state machine, counts remaining balls and the BCD score, and tells the graphics generator when to freeze the ball and when to serve. Sits beside the graphics generator on the 50 MHz pixel clock domain. It consumes the per-frame refresh tick and the hit/miss events, and drives the still/serve controls and the score/status values for a text overlay.

## Interface
Parameters:
- NUM_BALLS, 3, balls per game (1..3).
- SERVE_FRAMES, 120, refresh ticks (2 s at 60 Hz) of forced pause after a miss and after game over.

Ports:
- clk  in  1  system clock (50 MHz pixel-domain clock)
- reset  in  1  synchronous, active-high
- refr_tick  in  1  one-cycle pulse per frame (start of vertical retrace)
- btn  in  2  paddle buttons, level, already synchronised
- hit  in  1  one-cycle pulse: ball bounced off paddle
- miss  in  1  one-cycle pulse: ball passed paddle
- gra_still  out  1  1 = graphics hold ball at serve position, paddle idle
- serve  out  1  one-cycle pulse: launch ball from serve position
- state  out  2  0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 OVER
- balls_left  out  2  remaining balls including the one in play
- score_bcd  out  8  two BCD digits, [7:4] tens, [3:0] units

## Operation
- any_btn = btn[1] | btn[0]. btn_prev is a register of any_btn. start_edge = any_btn & ~btn_prev.
- timer: width $clog2(SERVE_FRAMES+1). Loaded with SERVE_FRAMES on entry to NEWBALL or OVER. Otherwise decrements on refr_tick while nonzero. Holds at 0.
- NEWGAME: gra_still=1. On start_edge:
  - go to PLAY
  - score_bcd<=0, balls_left<=NUM_BALLS
  - serve pulse
  - A button held through OVER does not restart the game; a fresh press is required.
- PLAY: gra_still=0.
  - miss with balls_left==1: balls_left<=0, go to OVER.
  - miss with balls_left>1: balls_left-1, go to NEWBALL.
  - hit without miss: score_bcd increments in BCD (09->10, 19->20), saturating at 99.
  - miss and hit in the same cycle: miss wins, score unchanged.
- NEWBALL: gra_still=1. When timer==0 and any_btn (level): go to PLAY with a serve pulse. hit/miss are ignored.
- OVER: gra_still=1. When timer==0: go to NEWGAME. The score of the finished game stays visible through OVER and NEWGAME until the next start.
- hit/miss outside PLAY are ignored. refr_tick only affects the timer.

## Timing
- All outputs are registered. A state change and its gra_still value appear on the cycle after the causing input.
- serve is high for exactly the one cycle in which state first reads PLAY.
- Score/balls updates are visible one cycle after hit/miss.
- Timer expiry: after a miss at frame F, the earliest serve is 1 cycle after the button is seen following the SERVE_FRAMES-th subsequent refr_tick. A refr_tick coincident with state entry is not counted.
- Reset values:
  - state=NEWGAME, gra_still=1, serve=0
  - balls_left=NUM_BALLS, score_bcd=8'h00
  - timer=0, btn_prev=1
  - btn_prev=1 blocks a start from a button held across reset.
- Reset mid-game: the synchronous reset dominates every transition in the same cycle. No serve pulse is issued on the reset cycle.

## Structure
- Shared pong_pkg:
  - state encoding constants (ST_NEWGAME..ST_OVER)
  - defaults NUM_BALLS_DEF=3, SERVE_FRAMES_DEF=120
  - BCD max constant 8'h99
- One sub-module, pong_bcd2_counter:
  - 2-digit BCD counter with synchronous clr and inc inputs, saturating at 99
  - clr has priority over inc
  - Instantiated once for score_bcd.
- Top module holds the FSM, timer, ball counter and btn edge register.

## Test plan
- Reset with btn=2'b01 held: state stays 0. Release, then press: state=1, serve pulses one cycle, balls_left=3, score=00.
- In PLAY, 11 hit pulses: score_bcd=8'h11. Continue to 99, then 3 more hits: score stays 8'h99.
- In PLAY with balls_left=3, miss: state=2, balls_left=2, gra_still=1.
  - Button held from before the miss: no serve until 120 refr_ticks have elapsed, then state=1 with serve.
- hit and miss in the same cycle with score=05: score stays 05, balls_left decrements.
- Third miss: state=3, balls_left=0. After 120 refr_ticks: state=0, score still shows the final value. The next press clears score to 00.
- Assert reset during NEWBALL with the timer mid-count: next cycle state=0, timer=0, balls_left=3, serve=0.
